// File: rtl/lap_chronometer_pkg.sv
// Shared state encoding, time-base constants and divisor helper for the lap chronometer.
package lap_chronometer_pkg;

  localparam int unsigned US_PER_S = 1000000;
  localparam int unsigned MS_PER_S = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } chrono_state_e;

  function automatic int unsigned prescale_div(input int unsigned freq_in, input logic use_us);
    return use_us ? (freq_in / US_PER_S) : (freq_in / MS_PER_S);
  endfunction

endpackage

// File: rtl/lap_chronometer_lap_fifo.sv
// Synchronous lap-capture FIFO with a registered head word that holds its last value when empty.
module lap_fifo
  import lap_chronometer_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         full,
  input  logic                         pop,
  output logic                         valid,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_fire, pop_fire;

  assign valid     = (cnt_q != '0);
  assign full      = (cnt_q == CW'(DEPTH));
  assign pop_fire  = pop && valid;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign push_fire = push && (!full || pop_fire);

  assign head_data = head_q;
  assign count     = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (push_fire) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_fire, pop_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d != '0) begin
      head_d = mem_d[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/lap_chronometer.sv
// Runtime-selectable us/ms chronometer with wrap or saturate counting and a lap-capture FIFO.
module lap_chronometer
  import lap_chronometer_pkg::*;
#(
  parameter int FREQ_IN            = 12000000,
  parameter int LIMIT_RECORD_TIMER = 1000,
  parameter int WRAP_MODE          = 0,
  parameter int LAP_DEPTH          = 4,
  localparam int CNT_W             = $clog2(LIMIT_RECORD_TIMER),
  localparam int LAP_CW            = $clog2(LAP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetChronometer,
  input  logic              enableTimmerCounter,
  input  logic              selectUnits,
  input  logic              clearTimer,
  input  logic              lapStrobe,
  input  logic              lapReady,
  output logic [CNT_W-1:0]  recordTimer,
  output logic              tick,
  output logic              overflow,
  output logic [CNT_W-1:0]  lapData,
  output logic              lapValid,
  output logic [LAP_CW-1:0] lapCount,
  output logic              lapDropped
);

  localparam int unsigned DIV_US = prescale_div(FREQ_IN, 1'b1);
  localparam int unsigned DIV_MS = prescale_div(FREQ_IN, 1'b0);
  localparam int          PW     = $clog2(DIV_MS + 1);

  localparam logic [PW-1:0]    LAST_US  = PW'(DIV_US - 1);
  localparam logic [PW-1:0]    LAST_MS  = PW'(DIV_MS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT_RECORD_TIMER - 1);

  chrono_state_e    state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             ovf_q, ovf_d;
  logic             sel_q, sel_d;
  logic             dropped_q, dropped_d;

  logic unit_change, counting, presc_last, at_limit, tick_event;
  logic fifo_full;

  assign sel_d       = selectUnits;
  assign unit_change = (selectUnits != sel_q);
  assign counting    = (state_q == ST_RUN) && enableTimmerCounter && !clearTimer && !unit_change;
  assign presc_last  = (presc_q == (selectUnits ? LAST_US : LAST_MS));
  assign at_limit    = (count_q == LAST_CNT);
  assign tick_event  = counting && presc_last;

  always_ff @(posedge clk) begin
    if (resetChronometer) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clearTimer) begin
      state_d = enableTimmerCounter ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (enableTimmerCounter) state_d = ST_RUN;
        ST_RUN: begin
          if (tick_event && at_limit && (WRAP_MODE == 0)) state_d = ST_HALT;
          else if (!enableTimmerCounter)                  state_d = ST_PAUSE;
        end
        ST_PAUSE: if (enableTimmerCounter) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // A unit switch restarts the prescaler without issuing a tick; clear outranks everything.
  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clearTimer) begin
      presc_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (unit_change) begin
      presc_d = '0;
    end else if (counting) begin
      if (presc_last) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (at_limit) begin
          ovf_d   = 1'b1;
          count_d = (WRAP_MODE != 0) ? '0 : count_q;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign dropped_d = dropped_q | (lapStrobe && fifo_full && !(lapValid && lapReady));

  always_ff @(posedge clk) begin
    if (resetChronometer) begin
      presc_q   <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      ovf_q     <= 1'b0;
      sel_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      ovf_q     <= ovf_d;
      sel_q     <= sel_d;
      dropped_q <= dropped_d;
    end
  end

  lap_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk       (clk),
    .reset     (resetChronometer),
    .push      (lapStrobe),
    .push_data (count_q),
    .full      (fifo_full),
    .pop       (lapReady),
    .valid     (lapValid),
    .head_data (lapData),
    .count     (lapCount)
  );

  assign recordTimer = count_q;
  assign tick        = tick_q;
  assign overflow    = ovf_q;
  assign lapDropped  = dropped_q;

endmodule

// File: tb/tb_lap_chronometer.sv
// Directed bench for lap_chronometer: saturating and wrapping instances share stimulus; lap reads are scoreboarded.
module tb_lap_chronometer;

  localparam int CNT_W  = 10;
  localparam int LAP_CW = 3;

  logic clk = 1'b0;
  logic reset_chrono, enable, select_units, clear_timer, lap_strobe, lap_ready;

  logic [CNT_W-1:0]  rec0, rec1, lap_data0, lap_data1;
  logic              tick0, tick1, ovf0, ovf1, lap_valid0, lap_valid1, lap_dropped0, lap_dropped1;
  logic [LAP_CW-1:0] lap_count0, lap_count1;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [CNT_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  lap_chronometer #(.WRAP_MODE(0)) dut0 (
    .clk(clk), .resetChronometer(reset_chrono), .enableTimmerCounter(enable),
    .selectUnits(select_units), .clearTimer(clear_timer), .lapStrobe(lap_strobe),
    .lapReady(lap_ready), .recordTimer(rec0), .tick(tick0), .overflow(ovf0),
    .lapData(lap_data0), .lapValid(lap_valid0), .lapCount(lap_count0), .lapDropped(lap_dropped0)
  );

  lap_chronometer #(.WRAP_MODE(1)) dut1 (
    .clk(clk), .resetChronometer(reset_chrono), .enableTimmerCounter(enable),
    .selectUnits(select_units), .clearTimer(clear_timer), .lapStrobe(lap_strobe),
    .lapReady(lap_ready), .recordTimer(rec1), .tick(tick1), .overflow(ovf1),
    .lapData(lap_data1), .lapValid(lap_valid1), .lapCount(lap_count1), .lapDropped(lap_dropped1)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic apply_stimulus(input logic en, input logic sel, input logic clr,
                                input logic strobe, input logic ready);
    enable       = en;
    select_units = sel;
    clear_timer  = clr;
    lap_strobe   = strobe;
    lap_ready    = ready;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until a tick shows on the saturating instance, capped by budget.
  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (!tick0 && n < budget);
  endtask

  task automatic wait_count(input int target, input int budget);
    int n;
    n = 0;
    while (rec0 != CNT_W'(target) && n < budget) begin
      next_cycle();
      n++;
    end
    check_output("wait_count", rec0, target);
  endtask

  // Scoreboard monitor: every accepted pop must present the oldest expected capture.
  always @(negedge clk) begin
    if (!reset_chrono && lap_valid0 && lap_ready) begin
      if (exp_q.size() == 0) begin
        checks_total++;
        $display("[TB] FAIL lap_pop_unexpected: got data %0d, expected no pop", lap_data0);
      end else begin
        check_output("lap_data", lap_data0, exp_q.pop_front());
      end
    end
  end

  initial begin
    int n, ticks, ticks0, cyc;

    reset_chrono = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) next_cycle();
    check_output("reset_record", rec0, 0);
    check_output("reset_tick", tick0, 0);
    check_output("reset_overflow", ovf0, 0);
    check_output("reset_lap_valid", lap_valid0, 0);
    check_output("reset_lap_count", lap_count0, 0);
    check_output("reset_lap_dropped", lap_dropped0, 0);
    reset_chrono = 1'b0;
    repeat (2) next_cycle();

    // Plan 1: us ticks every 12 clocks.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    wait_tick(40, n);
    check_output("first_tick_latency", n, 12);
    check_output("record_after_first_tick", rec0, 1);
    repeat (108) next_cycle();
    check_output("record_after_120", rec0, 10);
    check_output("tick_at_120", tick0, 1);

    // Plan 2: pause with prescaler at 5, resume takes 7 more clocks.
    repeat (5) next_cycle();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      if (tick0) ticks++;
    end
    check_output("pause_ticks", ticks, 0);
    check_output("pause_record", rec0, 10);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    wait_tick(40, n);
    check_output("resume_tick_latency", n, 7);
    check_output("resume_record", rec0, 11);

    // Plan 5: lap captures with consumer stalled, one overflowing capture.
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("clear_record", rec0, 0);
    for (int k = 0; k < 5; k++) begin
      wait_count(3 + 2 * k, 200);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      if (k < 4) exp_q.push_back(CNT_W'(3 + 2 * k));
      next_cycle();
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_output("lap_count_full", lap_count0, 4);
    check_output("lap_dropped_set", lap_dropped0, 1);
    check_output("lap_head_oldest", lap_data0, 3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6) next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("drain_leftover", exp_q.size(), 0);
    check_output("drain_lap_valid", lap_valid0, 0);
    check_output("drain_lap_count", lap_count0, 0);
    check_output("empty_holds_data", lap_data0, 9);

    // Refill, then push into a full FIFO while popping.
    wait_count(13, 200);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(CNT_W'(13));
      next_cycle();
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(CNT_W'(13));
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    check_output("full_push_pop_count", lap_count0, 4);
    check_output("full_push_pop_dropped", lap_dropped0, 1);

    // Plan 6: switch to ms mid-run, then reset with a full FIFO.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    wait_tick(13000, n);
    check_output("unit_switch_latency", n, 12000);
    check_output("unit_switch_record", rec0, 14);
    reset_chrono = 1'b1;
    next_cycle();
    exp_q.delete();
    check_output("rst2_record", rec0, 0);
    check_output("rst2_tick", tick0, 0);
    check_output("rst2_overflow", ovf0, 0);
    check_output("rst2_lap_data", lap_data0, 0);
    check_output("rst2_lap_valid", lap_valid0, 0);
    check_output("rst2_lap_count", lap_count0, 0);
    check_output("rst2_lap_dropped", lap_dropped0, 0);
    check_output("rst2_record_wrap", rec1, 0);

    // Plans 3 and 4: saturate versus wrap at the 1000-tick limit.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_chrono = 1'b0;
    ticks = 0;
    cyc   = 0;
    while (ticks < 999 && cyc < 13000) begin
      next_cycle();
      cyc++;
      if (tick1) ticks++;
    end
    check_output("sat_record_999", rec0, 999);
    check_output("sat_overflow_before_limit", ovf0, 0);
    check_output("wrap_record_999", rec1, 999);
    ticks = 0;
    cyc   = 0;
    while (ticks < 1 && cyc < 100) begin
      next_cycle();
      cyc++;
      if (tick1) ticks++;
    end
    check_output("wrap_record_zero", rec1, 0);
    check_output("wrap_overflow", ovf1, 1);
    check_output("sat_record_hold", rec0, 999);
    check_output("sat_overflow", ovf0, 1);
    ticks  = 0;
    ticks0 = 0;
    cyc    = 0;
    while (ticks < 10 && cyc < 200) begin
      next_cycle();
      cyc++;
      if (tick1) ticks++;
      if (tick0) ticks0++;
    end
    check_output("wrap_record_10", rec1, 10);
    check_output("halt_no_ticks", ticks0, 0);
    check_output("halt_record", rec0, 999);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("halt_clear_record", rec0, 0);
    check_output("halt_clear_overflow", ovf0, 0);
    check_output("wrap_clear_overflow", ovf1, 0);
    wait_tick(40, n);
    check_output("halt_clear_runs", n, 12);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
